// File: rtl/gauss_coeff_ctrl.sv
// gauss_coeff_ctrl
//   Coefficient configuration controller for the 5-tap Gaussian filter.
//   The ARM side writes a shadow bank one tap at a time. A commit sums the
//   shadow taps, and a bank that passes the check is copied to the live bank
//   at the next end-of-frame (falling vvalid). This keeps a frame from being
//   filtered with a mix of old and new coefficients.
//
// Ports
//   clk        pixel clock
//   rst        asynchronous active-high reset
//   vvalid     frame-valid from the video source (clk domain)
//   wr_en      shadow write strobe
//   wr_addr    tap index, 0..N-1
//   wr_data    coefficient value
//   commit     validate-and-schedule request (pulse)
//   wr_ack     one-cycle pulse: the previous-cycle write was accepted
//   reg_coeff  live coefficients, tap i at [i*CW +: CW]
//   busy       FSM not idle
//   pending    validated bank waiting for a frame boundary
//   err_sum    sticky: last commit failed the sum check
//   upd_pulse  one-cycle pulse in the cycle reg_coeff changes
//   upd_cnt    applied-update counter, wraps
module gauss_coeff_ctrl #(
  parameter int N                    = 5,
  parameter int CW                   = 8,
  parameter int COEFF_SUM            = 256,
  parameter logic [N*CW-1:0] DEF_COEFF = {8'd16, 8'd64, 8'd96, 8'd64, 8'd16}
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            vvalid,
  input  logic            wr_en,
  input  logic [2:0]      wr_addr,
  input  logic [CW-1:0]   wr_data,
  input  logic            commit,
  output logic            wr_ack,
  output logic [N*CW-1:0] reg_coeff,
  output logic            busy,
  output logic            pending,
  output logic            err_sum,
  output logic            upd_pulse,
  output logic [7:0]      upd_cnt
);

  // CW+3 bits holds the sum of up to 8 full-scale taps.
  localparam int ACCW = CW + 3;
  localparam int IW   = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_COMPARE, S_ARMED, S_APPLY
  } state_t;

  state_t                  state_q, state_d;
  logic [ACCW-1:0]         acc_q, acc_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [N-1:0][CW-1:0]    sh_q, sh_d;
  logic [N-1:0][CW-1:0]    live_q, live_d;
  logic                    vvalid_dly_q;
  logic                    wr_ack_q, wr_ack_d;
  logic                    busy_q, busy_d;
  logic                    pending_q, pending_d;
  logic                    err_q, err_d;
  logic                    upd_pulse_q, upd_pulse_d;
  logic [7:0]              upd_cnt_q, upd_cnt_d;
  logic                    wr_acc;
  logic                    fe;

  // End of frame: vvalid was high last cycle and is low now.
  assign fe = vvalid_dly_q & ~vvalid;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    idx_d       = idx_q;
    sh_d        = sh_q;
    live_d      = live_q;
    err_d       = err_q;
    upd_cnt_d   = upd_cnt_q;
    upd_pulse_d = 1'b0;

    // Writes land only in IDLE, so the bank cannot move under the check
    // or while a validated bank waits for the frame boundary.
    wr_acc = wr_en && (state_q == S_IDLE) && (int'(wr_addr) < N);
    for (int i = 0; i < N; i++) begin
      if (wr_acc && (wr_addr == 3'(i))) sh_d[i] = wr_data;
    end
    wr_ack_d = wr_acc;

    case (state_q)
      S_IDLE: begin
        if (commit) begin
          state_d = S_CHECK;
          acc_d   = '0;
          idx_d   = '0;
          err_d   = 1'b0;
        end
      end
      S_CHECK: begin
        acc_d = acc_q + ACCW'(sh_q[idx_q]);
        idx_d = idx_q + IW'(1);
        if (idx_q == IW'(N - 1)) state_d = S_COMPARE;
      end
      S_COMPARE: begin
        if (acc_q == ACCW'(COEFF_SUM)) begin
          state_d = S_ARMED;
        end else begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_ARMED: begin
        if (fe) state_d = S_APPLY;
      end
      S_APPLY: begin
        live_d      = sh_q;
        upd_pulse_d = 1'b1;
        upd_cnt_d   = upd_cnt_q + 8'd1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Status flags track the next state so they are registered alongside it.
    busy_d    = (state_d != S_IDLE);
    pending_d = (state_d == S_ARMED);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      acc_q        <= '0;
      idx_q        <= '0;
      sh_q         <= DEF_COEFF;
      live_q       <= DEF_COEFF;
      vvalid_dly_q <= 1'b0;
      wr_ack_q     <= 1'b0;
      busy_q       <= 1'b0;
      pending_q    <= 1'b0;
      err_q        <= 1'b0;
      upd_pulse_q  <= 1'b0;
      upd_cnt_q    <= 8'd0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      idx_q        <= idx_d;
      sh_q         <= sh_d;
      live_q       <= live_d;
      vvalid_dly_q <= vvalid;
      wr_ack_q     <= wr_ack_d;
      busy_q       <= busy_d;
      pending_q    <= pending_d;
      err_q        <= err_d;
      upd_pulse_q  <= upd_pulse_d;
      upd_cnt_q    <= upd_cnt_d;
    end
  end

  assign wr_ack    = wr_ack_q;
  assign reg_coeff = live_q;
  assign busy      = busy_q;
  assign pending   = pending_q;
  assign err_sum   = err_q;
  assign upd_pulse = upd_pulse_q;
  assign upd_cnt   = upd_cnt_q;

endmodule

// File: tb/tb_gauss_coeff_ctrl.sv
// Directed bench for gauss_coeff_ctrl: a table of coefficient banks with
// hand-computed outcomes, then hand-written multi-cycle corner cases.
module tb_gauss_coeff_ctrl;

  localparam logic [39:0] DEF = 40'h1040604010;

  logic        clk = 1'b0;
  logic        rst;
  logic        vvalid;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [7:0]  wr_data;
  logic        commit;
  logic        wr_ack;
  logic [39:0] reg_coeff;
  logic        busy;
  logic        pending;
  logic        err_sum;
  logic        upd_pulse;
  logic [7:0]  upd_cnt;

  int tests = 0;
  int fails = 0;

  gauss_coeff_ctrl dut (
    .clk(clk), .rst(rst), .vvalid(vvalid), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .commit(commit), .wr_ack(wr_ack), .reg_coeff(reg_coeff),
    .busy(busy), .pending(pending), .err_sum(err_sum), .upd_pulse(upd_pulse),
    .upd_cnt(upd_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [39:0] bank;     // taps to write, tap 0 in LSBs
    logic        exp_err;  // sum check fails
    logic [39:0] exp_reg;  // live bank after the following frame end
    logic [7:0]  exp_cnt;  // applied updates so far
  } vec_t;

  vec_t vt [8];

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_tap(input int i, input logic [7:0] d, input logic exp_ack);
    wr_en = 1'b1; wr_addr = 3'(i); wr_data = d;
    step();
    wr_en = 1'b0;
    chk($sformatf("wr_ack tap%0d", i), {63'b0, wr_ack}, {63'b0, exp_ack});
  endtask

  task automatic write_bank(input logic [39:0] b);
    for (int i = 0; i < 5; i++) write_tap(i, b[i*8 +: 8], 1'b1);
  endtask

  // Commit, then stop in the cycle after COMPARE (t+7).
  task automatic do_commit();
    commit = 1'b1;
    step();
    commit = 1'b0;
    chk("err clr on commit", {63'b0, err_sum}, 64'd0);
    chk("busy in check", {63'b0, busy}, 64'd1);
    repeat (6) step();
  endtask

  // Falling vvalid, then sample two edges later where the update is visible.
  task automatic frame_end();
    vvalid = 1'b0;
    step();
    chk("no pulse in apply", {63'b0, upd_pulse}, 64'd0);
    chk("pending low in apply", {63'b0, pending}, 64'd0);
    step();
  endtask

  initial begin
    vt[0] = '{40'h0820B02008, 1'b0, 40'h0820B02008, 8'd1};
    vt[1] = '{40'h1040614010, 1'b1, 40'h0820B02008, 8'd1};
    vt[2] = '{40'h1040604010, 1'b0, 40'h1040604010, 8'd2};
    vt[3] = '{40'h0001FF0000, 1'b0, 40'h0001FF0000, 8'd3};
    vt[4] = '{40'h000000FFFF, 1'b1, 40'h0001FF0000, 8'd3};
    vt[5] = '{40'h3333343333, 1'b0, 40'h3333343333, 8'd4};
    vt[6] = '{40'h0000000000, 1'b1, 40'h3333343333, 8'd4};
    vt[7] = '{40'h00000001FF, 1'b0, 40'h00000001FF, 8'd5};

    rst = 1'b1; vvalid = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; commit = 1'b0;
    #12;
    chk("rst reg_coeff", {24'b0, reg_coeff}, {24'b0, DEF});
    chk("rst busy", {63'b0, busy}, 64'd0);
    chk("rst pending", {63'b0, pending}, 64'd0);
    chk("rst err_sum", {63'b0, err_sum}, 64'd0);
    chk("rst upd_pulse", {63'b0, upd_pulse}, 64'd0);
    chk("rst upd_cnt", {56'b0, upd_cnt}, 64'd0);
    chk("rst wr_ack", {63'b0, wr_ack}, 64'd0);
    rst = 1'b0;
    vvalid = 1'b1;
    step(); step();

    // Table: write bank, commit, check verdict, then a frame end.
    for (int v = 0; v < 8; v++) begin
      write_bank(vt[v].bank);
      do_commit();
      chk($sformatf("v%0d err_sum", v), {63'b0, err_sum}, {63'b0, vt[v].exp_err});
      chk($sformatf("v%0d pending", v), {63'b0, pending}, {63'b0, ~vt[v].exp_err});
      chk($sformatf("v%0d busy", v), {63'b0, busy}, {63'b0, ~vt[v].exp_err});
      frame_end();
      chk($sformatf("v%0d reg_coeff", v), {24'b0, reg_coeff}, {24'b0, vt[v].exp_reg});
      chk($sformatf("v%0d upd_pulse", v), {63'b0, upd_pulse}, {63'b0, ~vt[v].exp_err});
      chk($sformatf("v%0d upd_cnt", v), {56'b0, upd_cnt}, {56'b0, vt[v].exp_cnt});
      chk($sformatf("v%0d busy after", v), {63'b0, busy}, 64'd0);
      vvalid = 1'b1;
      step();
      chk($sformatf("v%0d pulse one cycle", v), {63'b0, upd_pulse}, 64'd0);
    end

    // Writes and commits are dropped while ARMED.
    write_bank(DEF);
    do_commit();
    chk("blk pending", {63'b0, pending}, 64'd1);
    write_tap(0, 8'hFF, 1'b0);
    commit = 1'b1; step(); commit = 1'b0;
    repeat (3) step();
    chk("blk still pending", {63'b0, pending}, 64'd1);
    chk("blk live unchanged", {24'b0, reg_coeff}, 64'h00000001FF);
    frame_end();
    chk("blk applied bank", {24'b0, reg_coeff}, {24'b0, DEF});
    chk("blk upd_cnt", {56'b0, upd_cnt}, 64'd6);
    vvalid = 1'b1; step();
    chk("blk idle after commit-in-armed", {63'b0, busy}, 64'd0);
    write_tap(5, 8'h55, 1'b0);

    // Write together with commit is included in the sum (16->17 on tap 4).
    wr_en = 1'b1; wr_addr = 3'd4; wr_data = 8'd17; commit = 1'b1;
    step();
    wr_en = 1'b0; commit = 1'b0;
    chk("same-cycle wr_ack", {63'b0, wr_ack}, 64'd1);
    repeat (5) step();
    chk("same-cycle err before verdict", {63'b0, err_sum}, 64'd0);
    step();
    chk("same-cycle err_sum", {63'b0, err_sum}, 64'd1);
    chk("same-cycle busy", {63'b0, busy}, 64'd0);
    write_tap(4, 8'd16, 1'b1);

    // A frame end during CHECK is not remembered.
    commit = 1'b1; step(); commit = 1'b0;
    vvalid = 1'b0; step();
    vvalid = 1'b1; repeat (5) step();
    chk("fe-in-check pending", {63'b0, pending}, 64'd1);
    repeat (4) step();
    chk("fe-in-check still pending", {63'b0, pending}, 64'd1);
    chk("fe-in-check no update", {56'b0, upd_cnt}, 64'd6);
    frame_end();
    chk("fe-in-check applied", {56'b0, upd_cnt}, 64'd7);
    vvalid = 1'b1; step();

    // Reset while ARMED restores defaults.
    write_bank(40'h0820B02008);
    do_commit();
    frame_end();
    chk("pre-rst live", {24'b0, reg_coeff}, 64'h0820B02008);
    vvalid = 1'b1; step();
    write_bank(40'h3333343333);
    do_commit();
    chk("pre-rst pending", {63'b0, pending}, 64'd1);
    rst = 1'b1;
    #2;
    chk("armed rst reg_coeff", {24'b0, reg_coeff}, {24'b0, DEF});
    chk("armed rst upd_cnt", {56'b0, upd_cnt}, 64'd0);
    chk("armed rst busy", {63'b0, busy}, 64'd0);
    chk("armed rst pending", {63'b0, pending}, 64'd0);
    rst = 1'b0;
    step(); step();

    // 256 applies of the default bank wrap the counter back to 0.
    for (int k = 0; k < 256; k++) begin
      do_commit();
      frame_end();
      if (k == 254) chk("wrap cnt 255", {56'b0, upd_cnt}, 64'd255);
      if (k == 255) begin
        chk("wrap cnt 0", {56'b0, upd_cnt}, 64'd0);
        chk("wrap pulse", {63'b0, upd_pulse}, 64'd1);
      end
      vvalid = 1'b1;
      step();
    end
    chk("wrap live default", {24'b0, reg_coeff}, {24'b0, DEF});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
